// File: rtl/fsm_run_logger_if.sv
// Record drain handshake between the run logger and its consumer.
// The logger drives valid/data, the consumer answers with ready.
interface fsm_run_logger_if #(
  parameter int LEN_W = 8
);
  logic             rec_valid;
  logic [LEN_W-1:0] rec_data;
  logic             rec_ready;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/fsm_run_logger.sv
// Measures each contiguous run of z high and queues the run lengths in a FIFO.
// Also counts run starts and flags records dropped while the FIFO is full.
module fsm_run_logger #(
  parameter int LEN_W = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    z,
  input  logic                    clr,
  fsm_run_logger_if.master        rec,
  output logic [CNT_W-1:0]        event_count,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic             z_d;
  logic             start, push, pop, full, wr_en, drop, valid;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LEN_W-1:0] mem [DEPTH];

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

  // Run tracker: start on a rising z, count while high, emit a record on the fall
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    start     = 1'b0;
    push      = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
      len_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (z && !z_d) begin
            state_nxt = RUN;
            len_nxt   = LEN_W'(1);
            start     = 1'b1;
          end
        end
        RUN: begin
          if (z) begin
            len_nxt = sat_inc(len);
          end else begin
            push      = 1'b1;
            state_nxt = IDLE;
            len_nxt   = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign valid = (fill != '0);
  assign full  = (fill == FULL_CNT);
  assign pop   = valid && rec.rec_ready && !clr;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign rec.rec_valid = valid;
  assign rec.rec_data  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= IDLE;
      len         <= '0;
      z_d         <= 1'b0;
      event_count <= '0;
      overflow    <= 1'b0;
      fill        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
      z_d   <= z;
      if (clr) begin
        event_count <= '0;
        overflow    <= 1'b0;
        fill        <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
      end else begin
        if (start) event_count <= event_count + CNT_W'(1);
        if (drop) overflow <= 1'b1;
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (wr_en && !pop) fill <= fill + (AW + 1)'(1);
        else if (pop && !wr_en) fill <= fill - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_ptr] <= len;
  end

endmodule

// File: tb/tb_fsm_run_logger.sv
// Directed bench for fsm_run_logger: one task per scenario, inline checks.
module tb_fsm_run_logger;

  logic        Clock;
  logic        Resetn;
  logic        z;
  logic        clr;
  logic [15:0] event_count;
  logic        overflow;
  logic [2:0]  fill;

  int checks;
  int failures;

  fsm_run_logger_if #(.LEN_W(8)) rec_if ();

  fsm_run_logger #(.LEN_W(8), .DEPTH(4), .CNT_W(16)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .z           (z),
    .clr         (clr),
    .rec         (rec_if.master),
    .event_count (event_count),
    .overflow    (overflow),
    .fill        (fill)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // z high for n edges, then low for one edge (the push edge)
  task automatic run(input int n);
    z = 1'b1;
    repeat (n) step();
    z = 1'b0;
    step();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    z = 1'b0;
    clr = 1'b0;
    rec_if.rec_ready = 1'b0;
    step();
    checks++;
    if (rec_if.rec_valid !== 1'b0 || rec_if.rec_data !== 8'd0 || event_count !== 16'd0 ||
        overflow !== 1'b0 || fill !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b data=%0d cnt=%0d ovf=%b fill=%0d, required all 0",
               rec_if.rec_valid, rec_if.rec_data, event_count, overflow, fill);
    end
    Resetn = 1'b1;
    step();
  endtask

  task automatic test_single_run();
    rec_if.rec_ready = 1'b1;
    z = 1'b1;
    repeat (3) step();
    z = 1'b0;
    checks++;
    if (rec_if.rec_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early_valid: got %b required 0", rec_if.rec_valid);
    end
    step();
    checks++;
    if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== 8'd3) begin
      failures++;
      $display("FAIL single_record: valid=%b data=%0d required valid=1 data=3",
               rec_if.rec_valid, rec_if.rec_data);
    end
    checks++;
    if (event_count !== 16'd1) begin
      failures++;
      $display("FAIL single_count: got %0d required 1", event_count);
    end
    step();
    checks++;
    if (rec_if.rec_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_popped: valid=%b required 0", rec_if.rec_valid);
    end
  endtask

  task automatic test_fifo_full();
    do_clr();
    rec_if.rec_ready = 1'b0;
    for (int n = 1; n <= 5; n++) run(n);
    checks++;
    if (fill !== 3'd4 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL full_state: fill=%0d ovf=%b required fill=4 ovf=1", fill, overflow);
    end
    checks++;
    if (event_count !== 16'd5) begin
      failures++;
      $display("FAIL full_count: got %0d required 5", event_count);
    end
    step();
    checks++;
    if (rec_if.rec_data !== 8'd1) begin
      failures++;
      $display("FAIL full_head_stable: got %0d required 1", rec_if.rec_data);
    end
    rec_if.rec_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== 8'(i)) begin
        failures++;
        $display("FAIL full_drain_%0d: valid=%b data=%0d required valid=1 data=%0d",
                 i, rec_if.rec_valid, rec_if.rec_data, i);
      end
      step();
    end
    rec_if.rec_ready = 1'b0;
    checks++;
    if (rec_if.rec_valid !== 1'b0 || fill !== 3'd0) begin
      failures++;
      $display("FAIL full_empty: valid=%b fill=%0d required 0 0", rec_if.rec_valid, fill);
    end
  endtask

  task automatic test_saturation();
    do_clr();
    rec_if.rec_ready = 1'b0;
    run(300);
    checks++;
    if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== 8'd255) begin
      failures++;
      $display("FAIL sat_record: valid=%b data=%0d required valid=1 data=255",
               rec_if.rec_valid, rec_if.rec_data);
    end
    checks++;
    if (event_count !== 16'd1) begin
      failures++;
      $display("FAIL sat_count: got %0d required 1", event_count);
    end
  endtask

  task automatic test_push_pop_full();
    do_clr();
    rec_if.rec_ready = 1'b0;
    for (int n = 1; n <= 4; n++) run(n);
    z = 1'b1;
    repeat (7) step();
    z = 1'b0;
    rec_if.rec_ready = 1'b1;
    step();
    rec_if.rec_ready = 1'b0;
    checks++;
    if (fill !== 3'd4 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL pp_state: fill=%0d ovf=%b required fill=4 ovf=0", fill, overflow);
    end
    rec_if.rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_v;
      exp_v = (i == 3) ? 8'd7 : 8'(i + 2);
      checks++;
      if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== exp_v) begin
        failures++;
        $display("FAIL pp_drain_%0d: valid=%b data=%0d required valid=1 data=%0d",
                 i, rec_if.rec_valid, rec_if.rec_data, exp_v);
      end
      step();
    end
    rec_if.rec_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_clr();
    rec_if.rec_ready = 1'b0;
    run(2);
    z = 1'b1;
    repeat (5) step();
    #2 Resetn = 1'b0;
    #1;
    checks++;
    if (rec_if.rec_valid !== 1'b0 || rec_if.rec_data !== 8'd0 || event_count !== 16'd0 ||
        overflow !== 1'b0 || fill !== 3'd0) begin
      failures++;
      $display("FAIL arst_clear: valid=%b data=%0d cnt=%0d ovf=%b fill=%0d, required all 0",
               rec_if.rec_valid, rec_if.rec_data, event_count, overflow, fill);
    end
    #1 Resetn = 1'b1;
    step();
    checks++;
    if (event_count !== 16'd1) begin
      failures++;
      $display("FAIL arst_restart_count: got %0d required 1", event_count);
    end
    z = 1'b0;
    step();
    checks++;
    if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== 8'd1 || fill !== 3'd1) begin
      failures++;
      $display("FAIL arst_restart_record: valid=%b data=%0d fill=%0d required 1 1 1",
               rec_if.rec_valid, rec_if.rec_data, fill);
    end
  endtask

  task automatic test_clr_mid_run();
    do_clr();
    rec_if.rec_ready = 1'b0;
    run(1);
    run(2);
    z = 1'b1;
    repeat (2) step();
    do_clr();
    checks++;
    if (fill !== 3'd0 || event_count !== 16'd0 || overflow !== 1'b0 || rec_if.rec_valid !== 1'b0) begin
      failures++;
      $display("FAIL clr_state: fill=%0d cnt=%0d ovf=%b valid=%b required all 0",
               fill, event_count, overflow, rec_if.rec_valid);
    end
    repeat (2) step();
    z = 1'b0;
    step();
    checks++;
    if (fill !== 3'd0 || event_count !== 16'd0) begin
      failures++;
      $display("FAIL clr_no_record: fill=%0d cnt=%0d required 0 0", fill, event_count);
    end
    run(2);
    checks++;
    if (rec_if.rec_valid !== 1'b1 || rec_if.rec_data !== 8'd2 || event_count !== 16'd1) begin
      failures++;
      $display("FAIL clr_new_run: valid=%b data=%0d cnt=%0d required 1 2 1",
               rec_if.rec_valid, rec_if.rec_data, event_count);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_run();
    test_fifo_full();
    test_saturation();
    test_push_pop_full();
    test_async_reset();
    test_clr_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_run_logger.md
# fsm_run_logger

Downstream consumer of the simple sequence-detector FSM's `z` output. It measures each contiguous run of `z` high in clock cycles and stores the lengths as records in a small FIFO. Software or a test harness drains the FIFO through a valid/ready handshake. The block also keeps a running count of detections and a sticky overflow flag for records lost when the FIFO is full.

## Interface
Parameters:
- `LEN_W`, 8: width of a run-length record. Saturates at 2^LEN_W-1.
- `DEPTH`, 4: FIFO depth in records. Power of two, at least 2.
- `CNT_W`, 16: width of the detection counter. Wraps.

Ports:
- `Clock`  in  1  sole clock. All state updates on posedge.
- `Resetn`  in  1  reset. Asynchronous, active-low.
- `z`  in  1  detector output, sampled on every posedge.
- `clr`  in  1  synchronous clear of FIFO, counter, overflow and current run.
- `rec_valid`  out  1  FIFO non-empty.
- `rec_data`  out  LEN_W  head record. Valid only while `rec_valid`=1.
- `rec_ready`  in  1  consumer accepts head record.
- `event_count`  out  CNT_W  number of runs started since reset/clr.
- `overflow`  out  1  sticky. Set when a record is dropped.
- `fill`  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- A `z_d` register holds the previous sample of `z`. Reset value is 0. `clr` does not affect it.
- Run tracker FSM has two states, IDLE and RUN. A `len` register holds the current run length.
  - IDLE -> RUN when z=1 and z_d=0. `len` <= 1. `event_count` increments, modulo 2^CNT_W.
  - RUN with z=1: `len` <= len+1, saturating at 2^LEN_W-1.
  - RUN with z=0: push `len` into the FIFO, go to IDLE.
- Push when the FIFO is full and no pop occurs in the same cycle: record discarded, `overflow` <= 1, FIFO unchanged.
- Pop happens on a posedge where `rec_valid`=1 and `rec_ready`=1. `rec_ready` is ignored while empty.
- Simultaneous push and pop is always legal, including when full. Both take effect and `fill` is unchanged. No drop occurs.
- Push into an empty FIFO does not bypass: the record appears on the next cycle.
- `rec_data` is driven directly from the head entry. It is stable while `rec_valid`=1 and `rec_ready`=0.
- `clr`=1 has priority over all other actions in that cycle:
  - FIFO emptied, `event_count`=0, `overflow`=0, FSM forced to IDLE, `len`=0.
  - No push or pop occurs that cycle.
  - A run in progress is discarded without a record.
  - If `z` stays high after `clr`, no new run starts until `z` falls and rises again, because `z_d`=1 blocks the IDLE->RUN transition.
- Reset values: FSM=IDLE, len=0, z_d=0, `rec_valid`=0, `rec_data`=0, `event_count`=0, `overflow`=0, `fill`=0.
  - If `z`=1 on the first posedge after reset, it counts as a run start.

## Timing
- Run of N cycles: z=1 on edges k..k+N-1 and z=0 on edge k+N.
  - Record is pushed at edge k+N.
  - `rec_valid` rises after edge k+N (empty FIFO), with `rec_data`=min(N, 2^LEN_W-1).
- `event_count` updates after start edge k. It is 1 cycle behind the rising edge of `z`.
- Minimum run N=1 yields record 1. Runs separated by a single low cycle are recorded separately.
- Throughput: one record per 2 cycles maximum in, one record per cycle out.
- An asynchronous `Resetn` assertion mid-run immediately clears all state and outputs. No partial record survives.
- Deassert `Resetn` synchronously to `Clock` externally. The block adds no synchronizer.

## Test plan
- Single run, `rec_ready`=1: z high 3 cycles then low -> one record of 3. `rec_valid` high exactly 1 cycle after the fall edge. `event_count`=1.
- FIFO full, DEPTH=4, `rec_ready`=0: five runs of lengths 1,2,3,4,5 -> `fill`=4 and `overflow`=1. Draining yields 1,2,3,4 in order, then `rec_valid`=0. `event_count`=5.
- Saturation, LEN_W=8: z high 300 cycles -> record 255. `event_count`=1.
- Push and pop together while full: FIFO holds 4 records, `rec_ready`=1 on the cycle a run of 7 ends -> `fill` stays 4, `overflow` stays 0. The last record drained is 7.
- Async reset mid-run: z high 5 cycles, `Resetn` pulsed low between edges -> all outputs 0 immediately. `z` held high through the deassertion -> a new run starts on the first edge after reset.
- `clr` with z high: a run is in progress, 2 records are stored, and `clr` is pulsed for 1 cycle -> `fill`=0, `event_count`=0, no record when `z` falls. A new 2-cycle run afterwards gives record 2 and `event_count`=1.
